// File: rtl/mdu_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
// The master drives the request; the slave (mdu_unit) returns busy and HI/LO.
interface mdu_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, hi, lo
   );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// MULT/DIV results land after a fixed busy window; MTHI/MTLO write immediately.
module mdu_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   mdu_unit_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_n;
   logic [5:0]       cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             load, finish, mt_hi, mt_lo;
   logic             res_we;
   logic [WIDTH-1:0] res_hi, res_lo;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      finish  = 1'b0;
      mt_hi   = 1'b0;
      mt_lo   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               unique case (bus.op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     load    = 1'b1;
                     state_n = RUN;
                  end
                  OP_MTHI: mt_hi = 1'b1;
                  OP_MTLO: mt_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // counter reaches zero on this edge
            if (cnt <= 6'd1) begin
               finish  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ---------------- arithmetic on latched operands ----------------
   logic signed [2*WIDTH-1:0] mul_a_s, mul_b_s, prod_s;
   logic        [2*WIDTH-1:0] mul_a_u, mul_b_u, prod_u;
   logic                      div_zero, div_ovf;
   logic        [WIDTH-1:0]   b_div;
   logic signed [WIDTH-1:0]   dvd_s, dvs_s, quo_s, rem_s;
   logic        [WIDTH-1:0]   quo_u, rem_u;

   assign mul_a_s = {{WIDTH{a_q[WIDTH-1]}}, a_q};
   assign mul_b_s = {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod_s  = mul_a_s * mul_b_s;
   assign mul_a_u = {{WIDTH{1'b0}}, a_q};
   assign mul_b_u = {{WIDTH{1'b0}}, b_q};
   assign prod_u  = mul_a_u * mul_b_u;

   assign div_zero = (b_q == '0);
   assign div_ovf  = (op_q == OP_DIV[1:0]) && (a_q == MOST_NEG) && (b_q == '1);
   // divisor steered away from 0 and the overflow case so the dividers never see them
   assign b_div    = (div_zero || div_ovf) ? ONE : b_q;

   assign dvd_s = a_q;
   assign dvs_s = b_div;
   assign quo_s = dvd_s / dvs_s;
   assign rem_s = dvd_s % dvs_s;
   assign quo_u = a_q / b_div;
   assign rem_u = a_q % b_div;

   always_comb begin
      res_we = 1'b1;
      res_hi = '0;
      res_lo = '0;
      unique case (op_q)
         OP_MULT[1:0]: begin
            res_hi = prod_s[2*WIDTH-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
         end
         OP_MULTU[1:0]: begin
            res_hi = prod_u[2*WIDTH-1:WIDTH];
            res_lo = prod_u[WIDTH-1:0];
         end
         OP_DIV[1:0]: begin
            res_we = !div_zero;
            if (div_ovf) begin
               res_hi = '0;
               res_lo = MOST_NEG;
            end else begin
               res_hi = rem_s;
               res_lo = quo_s;
            end
         end
         default: begin
            res_we = !div_zero;
            res_hi = rem_u;
            res_lo = quo_u;
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (load) begin
            op_q <= bus.op[1:0];
            a_q  <= bus.a;
            b_q  <= bus.b;
            cnt  <= bus.op[1] ? DIV_LOAD : MULT_LOAD;
         end else if (state == RUN) begin
            cnt <= cnt - 6'd1;
         end

         if (finish && res_we) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
         if (mt_hi) hi_q <= bus.a;
         if (mt_lo) lo_q <= bus.a;
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus queues expected HI/LO and busy length,
// monitors pop and compare whenever a busy window closes.
module tb_mdu_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mdu_unit_if #(.WIDTH(32)) b32 ();
   mdu_unit_if #(.WIDTH(16)) b16 ();

   mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u32 (
      .clk(clk), .reset(reset), .bus(b32)
   );
   mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) u16 (
      .clk(clk), .reset(reset), .bus(b16)
   );

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t q32[$];
   exp_t q16[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- monitors ----------------
   logic prev32 = 1'b0, prev16 = 1'b0;
   int   cnt32 = 0, cnt16 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev32 = 1'b0; cnt32 = 0;
      end else if (b32.busy) begin
         cnt32++;
      end else if (prev32) begin
         if (q32.size() == 0) begin
            chk("w32_unexpected_result", 32'd1, 32'd0);
         end else begin
            e = q32.pop_front();
            chk({e.name, "_hi"}, b32.hi, e.hi);
            chk({e.name, "_lo"}, b32.lo, e.lo);
            chk({e.name, "_busy_cycles"}, 32'(cnt32), 32'(e.cycles));
         end
         cnt32 = 0;
      end
      prev32 = reset ? 1'b0 : b32.busy;
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev16 = 1'b0; cnt16 = 0;
      end else if (b16.busy) begin
         cnt16++;
      end else if (prev16) begin
         if (q16.size() == 0) begin
            chk("w16_unexpected_result", 32'd1, 32'd0);
         end else begin
            e = q16.pop_front();
            chk({e.name, "_hi"}, {16'h0, b16.hi}, e.hi);
            chk({e.name, "_lo"}, {16'h0, b16.lo}, e.lo);
            chk({e.name, "_busy_cycles"}, 32'(cnt16), 32'(e.cycles));
         end
         cnt16 = 0;
      end
      prev16 = reset ? 1'b0 : b16.busy;
   end

   // ---------------- stimulus helpers ----------------
   task automatic push32(input string n, input logic [31:0] h, input logic [31:0] l, input int c);
      exp_t e;
      e.name = n; e.hi = h; e.lo = l; e.cycles = c;
      q32.push_back(e);
   endtask

   task automatic push16(input string n, input logic [31:0] h, input logic [31:0] l, input int c);
      exp_t e;
      e.name = n; e.hi = h; e.lo = l; e.cycles = c;
      q16.push_back(e);
   endtask

   task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      b32.start = 1'b1; b32.op = op; b32.a = a; b32.b = b;
      @(negedge clk);
      b32.start = 1'b0;
   endtask

   task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      b16.start = 1'b1; b16.op = op; b16.a = a; b16.b = b;
      @(negedge clk);
      b16.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((b32.busy || b16.busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (b32.busy || b16.busy) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      b32.start = 1'b0; b32.op = 3'b000; b32.a = '0; b32.b = '0;
      b16.start = 1'b0; b16.op = 3'b000; b16.a = '0; b16.b = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_hi", b32.hi, 32'h0);
      chk("reset_lo", b32.lo, 32'h0);
      chk("reset_busy", {31'h0, b32.busy}, 32'h0);
      reset = 1'b0;

      push32("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      issue32(3'b000, 32'hFFFFFFFE, 32'd3);
      chk("mult_hold_hi", b32.hi, 32'h0);
      wait_idle("mult");

      push32("multu", 32'h00000002, 32'hFFFFFFFA, 5);
      issue32(3'b001, 32'hFFFFFFFE, 32'd3);
      wait_idle("multu");

      push32("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue32(3'b010, 32'hFFFFFFF9, 32'd2);
      wait_idle("div");

      push32("divu", 32'd1, 32'd3, 10);
      issue32(3'b011, 32'd7, 32'd2);
      wait_idle("divu");

      issue32(3'b100, 32'h12345678, 32'h0);
      chk("mthi_hi", b32.hi, 32'h12345678);
      chk("mthi_busy", {31'h0, b32.busy}, 32'h0);
      issue32(3'b101, 32'hCAFEF00D, 32'h0);
      chk("mtlo_lo", b32.lo, 32'hCAFEF00D);
      chk("mtlo_hi_kept", b32.hi, 32'h12345678);

      push32("div_by_zero", 32'h12345678, 32'hCAFEF00D, 10);
      issue32(3'b010, 32'd99, 32'd0);
      wait_idle("div_by_zero");

      issue32(3'b110, 32'hDEADBEEF, 32'd1);
      issue32(3'b111, 32'hDEADBEEF, 32'd1);
      chk("nop_busy", {31'h0, b32.busy}, 32'h0);
      chk("nop_hi", b32.hi, 32'h12345678);
      chk("nop_lo", b32.lo, 32'hCAFEF00D);

      // requests during busy must be dropped and the latched operands kept
      push32("mult_under_load", 32'h0, 32'd12, 5);
      @(negedge clk);
      b32.start = 1'b1; b32.op = 3'b000; b32.a = 32'd3; b32.b = 32'd4;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         b32.op = (i % 2 == 0) ? 3'b101 : 3'b010;
         b32.a  = 32'h5555_0000 + 32'(i);
         b32.b  = 32'd5;
         @(negedge clk);
         chk("busy_lo_frozen", b32.lo, 32'hCAFEF00D);
      end
      b32.start = 1'b0;
      wait_idle("mult_under_load");
      repeat (2) @(negedge clk);
      chk("no_late_mtlo", b32.lo, 32'd12);

      push32("div_ovf", 32'h0, 32'h80000000, 10);
      issue32(3'b010, 32'h80000000, 32'hFFFFFFFF);
      wait_idle("div_ovf");

      // reset in the middle of a divide
      issue32(3'b011, 32'd100, 32'd7);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_abort_busy", {31'h0, b32.busy}, 32'h0);
      chk("rst_abort_hi", b32.hi, 32'h0);
      chk("rst_abort_lo", b32.lo, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      chk("rst_no_late_hi", b32.hi, 32'h0);
      chk("rst_no_late_lo", b32.lo, 32'h0);

      // start on the first edge after reset release
      reset = 1'b1;
      @(negedge clk);
      push32("after_reset_divu", 32'd2, 32'd14, 10);
      reset = 1'b0;
      b32.start = 1'b1; b32.op = 3'b011; b32.a = 32'd100; b32.b = 32'd7;
      @(negedge clk);
      b32.start = 1'b0;
      chk("after_reset_busy", {31'h0, b32.busy}, 32'h1);
      wait_idle("after_reset_divu");

      // 16-bit instance with a single-cycle multiply
      push16("w16_mult", 32'h0000FFFF, 32'h0000FFFA, 1);
      issue16(3'b000, 16'hFFFE, 16'd3);
      wait_idle("w16_mult");
      push16("w16_multu", 32'h00000002, 32'h0000FFFA, 1);
      issue16(3'b001, 16'hFFFE, 16'd3);
      wait_idle("w16_multu");

      repeat (3) @(negedge clk);
      chk("q32_drained", 32'(q32.size()), 32'd0);
      chk("q16_drained", 32'(q16.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 32, meaning operand and HI/LO register width.
REQ-002 The module SHALL expose parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU (legal range 1..63).
REQ-003 The module SHALL expose parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU (legal range 1..63).
REQ-004 Port: clk  input  1  rising-edge clock; the only clock.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  E-stage request; op, a and b are sampled on the same rising edge.
REQ-007 Port: op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-008 Port: a  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data).
REQ-009 Port: b  input  WIDTH  rt operand (multiplier or divisor).
REQ-010 Port: busy  output  1  high while a MULT/DIV result is pending.
REQ-011 Port: hi  output  WIDTH  HI register, read by MFHI.
REQ-012 Port: lo  output  WIDTH  LO register, read by MFLO.

Function
REQ-013 The module SHALL have two states, IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-014 In IDLE, start with op 000..011 SHALL latch op, a and b, load a down-counter with MULT_CYCLES or DIV_CYCLES, and enter RUN on the same edge.
REQ-015 RUN SHALL decrement the counter on each edge; on the edge where it reaches 0, hi/lo SHALL be written and the state SHALL return to IDLE.
REQ-016 Latency: start sampled on edge T, busy high for edges T+1..T+N (N = cycle parameter), hi/lo valid and busy low after edge T+N.
REQ-017 hi/lo SHALL NOT change while busy=1; MFHI/MFLO reads during RUN return the previous values.
REQ-018 MULT SHALL be a signed WIDTH x WIDTH -> 2*WIDTH product with {hi,lo} = product; MULTU SHALL be the same, unsigned.
REQ-019 DIV SHALL put the signed quotient (truncated toward zero) in lo and the remainder (sign of the dividend) in hi; DIVU SHALL do the same, unsigned.
REQ-020 Divisor 0 (DIV or DIVU): the unit SHALL still run DIV_CYCLES busy cycles and leave hi/lo unchanged.
REQ-021 Signed overflow (DIV of most-negative by -1): the unit SHALL give lo = most-negative value and hi = 0.
REQ-022 MTHI/MTLO in IDLE SHALL write a into hi/lo on the sampling edge, with no busy cycle.
REQ-023 While busy=1, start SHALL be ignored for every op, and latched operands SHALL be unaffected; the stall unit SHALL hold any MD-class instruction in D while start|busy.
REQ-024 start with op 110/111 SHALL have no effect.
REQ-025 The result SHALL be computed from the latched operands only; changes on a/b/op during RUN SHALL have no effect.
REQ-026 When N = 1, busy SHALL be high for exactly one cycle.

Reset
REQ-027 reset SHALL immediately set state IDLE, counter 0, busy 0, hi 0, lo 0, and latched operands 0.
REQ-028 reset during RUN SHALL abort the operation with no later write to hi/lo.
REQ-029 start on the first edge after reset deassertion SHALL be accepted normally.

Verification
REQ-030 MULT a=0xFFFFFFFE, b=3 (WIDTH 32) -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-031 DIV a=-7, b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-032 MTHI a=0x12345678 with busy=0 -> hi=0x12345678 after one edge and busy stays 0; DIV with b=0 -> 10 busy cycles and hi/lo unchanged.
REQ-033 Start MULT, then assert MTLO and DIV starts at cycles 1..4 while busy -> those requests are ignored and only the MULT result lands; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Assert reset at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately, and no later update; the next start is accepted.
REQ-035 Re-run REQ-030 with WIDTH=16, MULT_CYCLES=1 -> one busy cycle and the correct 32-bit {hi,lo} result.
